i2s_tx: RTL and testbench

I2S_TX -- requirements
Module: i2s_tx

---
 rtl/audio_pkg.sv | 30 +++
 rtl/audio_pair_fifo.sv | 68 ++++++
 rtl/i2s_tx.sv | 184 ++++++++++++++++++
 tb/tb_i2s_tx.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared audio definitions for the I2S transmit path.
// Holds the sample and frame geometry, the stereo-pair record that flows
// through the FIFO, and the slot boundaries of the 64-slot I2S frame.
package audio_pkg;

  localparam int SAMPLE_W    = 24;
  localparam int FRAME_SLOTS = 64;
  localparam int SLOT_PER_CH = 32;
  localparam int SLOT_W      = $clog2(FRAME_SLOTS);

  typedef logic [SLOT_W-1:0] slot_t;

  typedef struct packed {
    logic [SAMPLE_W-1:0] left;
    logic [SAMPLE_W-1:0] right;
  } pair_t;

  // Word select goes high for the right half of the frame. Data bits start
  // one BCLK after each word-select edge (standard I2S delay), MSB first.
  localparam slot_t SLOT_RIGHT_WS = slot_t'(SLOT_PER_CH);
  localparam slot_t SLOT_L_FIRST  = slot_t'(1);
  localparam slot_t SLOT_L_LAST   = slot_t'(SAMPLE_W);
  localparam slot_t SLOT_R_FIRST  = slot_t'(SLOT_PER_CH + 1);
  localparam slot_t SLOT_R_LAST   = slot_t'(SLOT_PER_CH + SAMPLE_W);

  function automatic logic slot_in(input slot_t s, input slot_t first, input slot_t last);
    return (s >= first) && (s <= last);
  endfunction

endpackage

// File: rtl/audio_pair_fifo.sv
// Synchronous FIFO of stereo pairs (48 bits per entry), show-ahead read.
// Ports:
//   clk_i, rst_i    clock and synchronous active-high reset (empties FIFO)
//   push_i          write push_data_i; accepted if not full, or if a pop
//                   happens in the same cycle
//   push_data_i     pair to write
//   pop_i           drop the head entry (ignored when empty)
//   pop_data_o      current head entry (valid when empty_o = 0)
//   full_o, empty_o occupancy flags
module audio_pair_fifo
  import audio_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic  clk_i,
  input  logic  rst_i,
  input  logic  push_i,
  input  pair_t push_data_i,
  input  logic  pop_i,
  output pair_t pop_data_o,
  output logic  full_o,
  output logic  empty_o
);

  localparam int AW = $clog2(DEPTH);
  typedef logic [AW-1:0] ptr_t;
  typedef logic [AW:0]   cnt_t;
  localparam cnt_t FULL_CNT = cnt_t'(DEPTH);

  pair_t mem_q [DEPTH];
  ptr_t  wr_ptr_q, rd_ptr_q;
  cnt_t  count_q;
  logic  do_push, do_pop;

  assign empty_o    = (count_q == '0);
  assign full_o     = (count_q == FULL_CNT);
  assign do_pop     = pop_i & ~empty_o;
  // A pop in the same cycle frees the slot the push is about to use.
  assign do_push    = push_i & (~full_o | do_pop);
  assign pop_data_o = mem_q[rd_ptr_q];

  // NOTE: the storage array is not reset; count_q alone says which entries
  // are valid, so stale contents are never observed and no reset tree is spent.
  always_ff @(posedge clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  // NOTE: clocked state uses non-blocking (<=) so every register here samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + ptr_t'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + ptr_t'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + cnt_t'(1);
        2'b01:   count_q <= count_q - cnt_t'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/i2s_tx.sv
// I2S transmitter: pairs left/right samples, buffers pairs in a FIFO and
// serialises them as free-running 64-slot I2S frames (24-bit, MSB first,
// one-BCLK data delay).
// Ports:
//   clk_i, rst_i             system clock, synchronous active-high reset
//   data_l_i / valid_l_i     left sample and its one-cycle strobe
//   data_r_i / valid_r_i     right sample and its one-cycle strobe
//   i2s_bclk_o               bit clock, half-period BCLK_DIV clk_i cycles
//   i2s_lrclk_o              word select (0 = left)
//   i2s_sdata_o              serial data, changes with BCLK falling edges
//   underrun_o               pulse: frame started with FIFO empty
//   overrun_o                pulse: completed pair dropped, FIFO full
//   orphan_o                 pulse: right sample with no pending left
module i2s_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [SAMPLE_W-1:0] data_l_i,
  input  logic [SAMPLE_W-1:0] data_r_i,
  input  logic                valid_l_i,
  input  logic                valid_r_i,
  output logic                i2s_bclk_o,
  output logic                i2s_lrclk_o,
  output logic                i2s_sdata_o,
  output logic                underrun_o,
  output logic                overrun_o,
  output logic                orphan_o
);

  localparam int DIV_W = $clog2(BCLK_DIV);
  typedef logic [DIV_W-1:0] div_t;
  localparam div_t DIV_LAST = div_t'(BCLK_DIV - 1);

  div_t                div_q, div_d;
  logic                bclk_q, bclk_d;
  slot_t               slot_q, slot_d;
  logic                lrclk_q, lrclk_d;
  logic                sdata_q, sdata_d;
  logic [SAMPLE_W-1:0] l_sr_q, l_sr_d;
  logic [SAMPLE_W-1:0] r_sr_q, r_sr_d;
  logic                pend_q, pend_d;
  logic [SAMPLE_W-1:0] pend_left_q, pend_left_d;
  logic                push_q, push_d;
  pair_t               push_data_q, push_data_d;
  logic                orphan_q, orphan_d;
  logic                overrun_q, overrun_d;
  logic                underrun_q, underrun_d;

  logic  div_tc, bclk_fall, frame_start;
  slot_t slot_next;
  logic  fifo_full, fifo_empty;
  pair_t fifo_head;

  // Timebase: the slot counter only moves on BCLK falling edges and wraps
  // 63 -> 0 naturally in its 6-bit width.
  assign div_tc      = (div_q == DIV_LAST);
  assign bclk_fall   = div_tc & bclk_q;
  assign slot_next   = slot_q + slot_t'(1);
  assign frame_start = bclk_fall & (slot_next == '0);

  audio_pair_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .push_i     (push_q),
    .push_data_i(push_data_q),
    .pop_i      (frame_start),
    .pop_data_o (fifo_head),
    .full_o     (fifo_full),
    .empty_o    (fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      div_q       <= '0;
      bclk_q      <= 1'b1;
      slot_q      <= '1;
      lrclk_q     <= 1'b1;
      sdata_q     <= 1'b0;
      l_sr_q      <= '0;
      r_sr_q      <= '0;
      pend_q      <= 1'b0;
      pend_left_q <= '0;
      push_q      <= 1'b0;
      push_data_q <= '0;
      orphan_q    <= 1'b0;
      overrun_q   <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      div_q       <= div_d;
      bclk_q      <= bclk_d;
      slot_q      <= slot_d;
      lrclk_q     <= lrclk_d;
      sdata_q     <= sdata_d;
      l_sr_q      <= l_sr_d;
      r_sr_q      <= r_sr_d;
      pend_q      <= pend_d;
      pend_left_q <= pend_left_d;
      push_q      <= push_d;
      push_data_q <= push_data_d;
      orphan_q    <= orphan_d;
      overrun_q   <= overrun_d;
      underrun_q  <= underrun_d;
    end
  end

  always_comb begin : timebase_comb
    div_d  = div_tc ? '0 : div_q + div_t'(1);
    bclk_d = div_tc ? ~bclk_q : bclk_q;
    slot_d = bclk_fall ? slot_next : slot_q;
  end

  // NOTE: every signal driven here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin : serial_comb
    lrclk_d    = lrclk_q;
    sdata_d    = sdata_q;
    l_sr_d     = l_sr_q;
    r_sr_d     = r_sr_q;
    underrun_d = 1'b0;
    if (bclk_fall) begin
      lrclk_d = (slot_next >= SLOT_RIGHT_WS);
      sdata_d = 1'b0;
      if (frame_start) begin
        // An empty FIFO still starts a frame; it just carries silence.
        if (fifo_empty) begin
          l_sr_d     = '0;
          r_sr_d     = '0;
          underrun_d = 1'b1;
        end else begin
          l_sr_d = fifo_head.left;
          r_sr_d = fifo_head.right;
        end
      end else if (slot_in(slot_next, SLOT_L_FIRST, SLOT_L_LAST)) begin
        sdata_d = l_sr_q[SAMPLE_W-1];
        l_sr_d  = {l_sr_q[SAMPLE_W-2:0], 1'b0};
      end else if (slot_in(slot_next, SLOT_R_FIRST, SLOT_R_LAST)) begin
        sdata_d = r_sr_q[SAMPLE_W-1];
        r_sr_d  = {r_sr_q[SAMPLE_W-2:0], 1'b0};
      end
    end
  end

  // Pairing: a lone left waits in the pending register; a right completes it.
  // Completed pairs are staged one cycle before entering the FIFO.
  always_comb begin : pairing_comb
    pend_d      = pend_q;
    pend_left_d = pend_left_q;
    push_d      = 1'b0;
    push_data_d = push_data_q;
    orphan_d    = 1'b0;
    if (valid_l_i && valid_r_i) begin
      push_d      = 1'b1;
      push_data_d = '{left: data_l_i, right: data_r_i};
      pend_d      = 1'b0;
    end else if (valid_r_i) begin
      if (pend_q) begin
        push_d      = 1'b1;
        push_data_d = '{left: pend_left_q, right: data_r_i};
        pend_d      = 1'b0;
      end else begin
        orphan_d = 1'b1;
      end
    end else if (valid_l_i) begin
      pend_d      = 1'b1;
      pend_left_d = data_l_i;
    end
    // A full FIFO still accepts when the frame-start pop frees an entry.
    overrun_d = push_q & fifo_full & ~frame_start;
  end

  assign i2s_bclk_o  = bclk_q;
  assign i2s_lrclk_o = lrclk_q;
  assign i2s_sdata_o = sdata_q;
  assign underrun_o  = underrun_q;
  assign overrun_o   = overrun_q;
  assign orphan_o    = orphan_q;

endmodule

// File: tb/tb_i2s_tx.sv
// Bench for i2s_tx. Two instances share one stimulus: BCLK_DIV=2 carries the
// frame-content scoreboard, BCLK_DIV=8 is watched for BCLK/LRCK timing.
// The reference model is a queue of stereo pairs: each frame start pops one
// pair (or expects silence plus an underrun), each completed frame is decoded
// from the serial line and compared against that pair.
module tb_i2s_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_i;
  logic [23:0] data_l, data_r;
  logic        vl, vr;
  logic        bclk2, lr2, sd2, ur2, ovr2, orph2;
  logic        bclk8, lr8, sd8, ur8, ovr8, orph8;

  i2s_tx #(.BCLK_DIV(2), .FIFO_DEPTH(4)) dut2 (
    .clk_i(clk), .rst_i(rst_i),
    .data_l_i(data_l), .data_r_i(data_r), .valid_l_i(vl), .valid_r_i(vr),
    .i2s_bclk_o(bclk2), .i2s_lrclk_o(lr2), .i2s_sdata_o(sd2),
    .underrun_o(ur2), .overrun_o(ovr2), .orphan_o(orph2)
  );

  i2s_tx #(.BCLK_DIV(8), .FIFO_DEPTH(4)) dut8 (
    .clk_i(clk), .rst_i(rst_i),
    .data_l_i(data_l), .data_r_i(data_r), .valid_l_i(vl), .valid_r_i(vr),
    .i2s_bclk_o(bclk8), .i2s_lrclk_o(lr8), .i2s_sdata_o(sd8),
    .underrun_o(ur8), .overrun_o(ovr8), .orphan_o(orph8)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed { logic [23:0] l; logic [23:0] r; } ref_pair_t;
  localparam int MODEL_DEPTH = 4;

  ref_pair_t   mq[$];
  bit          pend_m;
  logic [23:0] pend_l_m;
  int          ovr_exp = 0, orph_exp = 0, ur_exp = 0;
  int          ovr_seen = 0, orph_seen = 0, ur_seen = 0;

  task automatic model_push(input logic [23:0] l, input logic [23:0] r);
    ref_pair_t p;
    p.l = l;
    p.r = r;
    if (mq.size() >= MODEL_DEPTH) ovr_exp++;
    else mq.push_back(p);
  endtask

  // ---------------- frame decoder / scoreboard (BCLK_DIV=2) ----------------
  logic        m_prev_b, m_prev_lr;
  bit          m_active;
  int          m_slot;
  logic [63:0] m_bits;
  bit          m_lr_ok, m_exp_ur, zeros_ok;
  logic        m_obs_ur;
  ref_pair_t   m_exp;
  logic [23:0] dl, dr;
  int          frames_started = 0, frames_done = 0;
  logic [23:0] last_l, last_r;
  logic        last_ur;

  always @(negedge clk) begin
    if (rst_i) begin
      m_active  = 1'b0;
      m_prev_b  = 1'b1;
      m_prev_lr = 1'b1;
      m_slot    = 0;
    end else begin
      if (orph2) orph_seen++;
      if (ovr2)  ovr_seen++;
      if (ur2)   ur_seen++;
      if (m_prev_b && !bclk2) begin
        if (m_prev_lr && !lr2) begin
          frames_started++;
          m_active = 1'b1;
          m_slot   = 0;
          m_bits   = '0;
          m_lr_ok  = 1'b1;
          m_obs_ur = ur2;
          if (mq.size() > 0) begin
            m_exp    = mq.pop_front();
            m_exp_ur = 1'b0;
          end else begin
            m_exp    = '0;
            m_exp_ur = 1'b1;
            ur_exp++;
          end
          chk("underrun_at_s0", ur2, m_exp_ur);
        end else if (m_active) begin
          m_slot++;
        end
        if (m_active) begin
          if (m_slot > 63) begin
            chk("lrclk_fall_at_s0", lr2, 0);
            m_active = 1'b0;
          end else begin
            m_bits[m_slot] = sd2;
            if (lr2 !== (m_slot >= 32)) m_lr_ok = 1'b0;
            if (m_slot == 63) begin
              for (int i = 0; i < 24; i++) begin
                dl[23-i] = m_bits[1+i];
                dr[23-i] = m_bits[33+i];
              end
              zeros_ok = 1'b1;
              for (int k = 0; k < 64; k++)
                if (!((k >= 1 && k <= 24) || (k >= 33 && k <= 56)) && m_bits[k] !== 1'b0)
                  zeros_ok = 1'b0;
              chk("frame_left", dl, m_exp.l);
              chk("frame_right", dr, m_exp.r);
              chk("frame_idle_slots_zero", zeros_ok, 1);
              chk("frame_lrclk_shape", m_lr_ok, 1);
              last_l  = dl;
              last_r  = dr;
              last_ur = m_obs_ur;
              frames_done++;
            end
          end
        end
      end
      m_prev_b  = bclk2;
      m_prev_lr = lr2;
    end
  end

  // ---------------- timing watcher (BCLK_DIV=8) ----------------
  int   cyc8 = 0, t_last_fall, t_falls;
  bit   t_lr_valid, fell, rose, lrchg;
  logic t_prev_b, t_prev_lr;

  always @(negedge clk) begin
    cyc8++;
    if (rst_i) begin
      t_prev_b    = 1'b1;
      t_prev_lr   = 1'b1;
      t_last_fall = -1;
      t_falls     = 0;
      t_lr_valid  = 1'b0;
    end else begin
      fell  = t_prev_b && !bclk8;
      rose  = !t_prev_b && bclk8;
      lrchg = (t_prev_lr !== lr8);
      if (rose && t_last_fall >= 0) chk("bclk8_low_time", cyc8 - t_last_fall, 8);
      if (fell) begin
        if (t_last_fall >= 0) chk("bclk8_period", cyc8 - t_last_fall, 16);
        t_last_fall = cyc8;
        t_falls++;
      end
      if (lrchg) begin
        chk("lrclk8_on_bclk_fall", fell, 1);
        if (t_lr_valid) chk("bclk8_per_lrclk_half", t_falls, 32);
        t_lr_valid = 1'b1;
        t_falls    = 0;
      end
      t_prev_b  = bclk8;
      t_prev_lr = lr8;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_same(input logic [23:0] l, input logic [23:0] r);
    @(negedge clk);
    data_l = l; data_r = r; vl = 1'b1; vr = 1'b1;
    @(negedge clk);
    vl = 1'b0; vr = 1'b0;
    model_push(l, r);
    pend_m = 1'b0;
  endtask

  task automatic send_left(input logic [23:0] l);
    @(negedge clk);
    data_l = l; vl = 1'b1;
    @(negedge clk);
    vl = 1'b0;
    pend_m   = 1'b1;
    pend_l_m = l;
  endtask

  task automatic send_right(input logic [23:0] r);
    @(negedge clk);
    data_r = r; vr = 1'b1;
    @(negedge clk);
    vr = 1'b0;
    if (pend_m) begin
      model_push(pend_l_m, r);
      pend_m = 1'b0;
    end else begin
      orph_exp++;
    end
  endtask

  task automatic wait_starts(input int n);
    int target = frames_started + n;
    for (int i = 0; i < 300 * n + 50 && frames_started < target; i++) @(negedge clk);
    chk("timeout_frame_start", frames_started >= target, 1);
  endtask

  task automatic wait_done(input int n);
    int target = frames_done + n;
    for (int i = 0; i < 300 * n + 50 && frames_done < target; i++) @(negedge clk);
    chk("timeout_frame_done", frames_done >= target, 1);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    logic [23:0] p_l [5];
    logic [23:0] p_r [5];
    logic [23:0] rl, rl2, rr;
    int n, mode, base;

    rst_i = 1'b1; vl = 1'b0; vr = 1'b0; data_l = '0; data_r = '0;
    pend_m = 1'b0; pend_l_m = '0;
    idle(4);
    chk("reset_outputs_div2", {bclk2, lr2, sd2, ur2, ovr2, orph2}, 6'b110000);
    chk("reset_outputs_div8", {bclk8, lr8, sd8, ur8, ovr8, orph8}, 6'b110000);

    // First frame after release underruns; the pair pushed during it plays next.
    rst_i = 1'b0;
    wait_starts(1);
    idle(4);
    send_same(24'hA5A5A5, 24'h5A5A5A);
    wait_done(2);
    chk("s1_first_frame_underruns", ur_seen, 1);
    chk("s1_left_bits", last_l, 24'hA5A5A5);
    chk("s1_right_bits", last_r, 24'h5A5A5A);
    chk("s1_no_underrun", last_ur, 0);

    // Five pairs into an empty 4-deep FIFO within one frame.
    wait_starts(1);
    idle(4);
    base = ovr_seen;
    for (int i = 0; i < 5; i++) begin
      p_l[i] = 24'($urandom);
      p_r[i] = 24'($urandom);
      send_same(p_l[i], p_r[i]);
    end
    idle(6);
    chk("s3_overrun_pulses", ovr_seen - base, 1);
    wait_done(5);
    chk("s3_fourth_pair_left", last_l, p_l[3]);
    chk("s3_fourth_pair_right", last_r, p_r[3]);

    // Right sample with nothing pending.
    wait_starts(1);
    idle(4);
    base = orph_seen;
    send_right(24'h000001);
    idle(4);
    chk("s4_orphan_pulses", orph_seen - base, 1);
    wait_done(2);
    chk("s4_next_frame_underruns", last_ur, 1);
    chk("s4_next_frame_silent", {last_l, last_r}, 48'h0);

    // Simultaneous strobes, extreme values.
    wait_starts(1);
    idle(4);
    send_same(24'h800000, 24'h7FFFFF);
    wait_done(2);
    chk("s5_left_msb_only", last_l, 24'h800000);
    chk("s5_right_all_but_msb", last_r, 24'h7FFFFF);

    // Random pairing traffic: simultaneous, split, and overwritten left.
    for (int f = 0; f < 6; f++) begin
      wait_starts(1);
      idle(3);
      n = $urandom_range(0, 2);
      for (int j = 0; j < n; j++) begin
        mode = $urandom_range(0, 2);
        rl = 24'($urandom); rl2 = 24'($urandom); rr = 24'($urandom);
        case (mode)
          0: send_same(rl, rr);
          1: begin send_left(rl); idle($urandom_range(0, 3)); send_right(rr); end
          default: begin send_left(rl); send_left(rl2); send_right(rr); end
        endcase
      end
    end
    for (int i = 0; i < 8 && mq.size() != 0; i++) wait_starts(1);

    // Reset mid-frame with two entries still buffered.
    wait_starts(1);
    idle(3);
    for (int i = 0; i < 3; i++) send_same(24'($urandom), 24'($urandom));
    wait_starts(1);
    for (int i = 0; i < 400 && !(m_active && m_slot == 40); i++) @(negedge clk);
    chk("s6_reached_slot40", m_slot, 40);
    rst_i = 1'b1;
    mq.delete();
    pend_m = 1'b0;
    @(negedge clk);
    chk("s6_reset_outputs_div2", {bclk2, lr2, sd2, ur2, ovr2, orph2}, 6'b110000);
    chk("s6_reset_outputs_div8", {bclk8, lr8, sd8, ur8, ovr8, orph8}, 6'b110000);
    idle(2);
    rst_i = 1'b0;
    wait_done(1);
    chk("s6_post_reset_underrun", last_ur, 1);
    chk("s6_post_reset_silent", {last_l, last_r}, 48'h0);

    idle(10);
    chk("total_underruns", ur_seen, ur_exp);
    chk("total_overruns", ovr_seen, ovr_exp);
    chk("total_orphans", orph_seen, orph_exp);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
